// File: rtl/regs_dbg_access_ctrl.sv
// Debug-port register-file access controller: waits for a halted core with no
// writeback in flight, performs one read or write through the debug port, then returns a response.
module regs_dbg_access_ctrl #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_req_valid_i,
  output logic        dbg_req_ready_o,
  input  logic        dbg_req_we_i,
  input  logic [4:0]  dbg_req_addr_i,
  input  logic [31:0] dbg_req_data_i,
  output logic        dbg_rsp_valid_o,
  input  logic        dbg_rsp_ready_i,
  output logic [31:0] dbg_rsp_data_o,
  output logic        dbg_rsp_err_o,
  input  logic        halted_i,
  input  logic        ex_we_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_addr_o,
  output logic [31:0] rf_wdata_o,
  input  logic [31:0] rf_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [15:0] LP_TMO = 16'(WAIT_MAX - 1);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_we;
  logic [4:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic [15:0] r_cnt;

  logic        w_accept;
  logic        w_slot;
  logic        w_tmo;
  logic        w_addr_nz;

  assign w_accept  = dbg_req_valid_i & dbg_req_ready_o;
  assign w_slot    = halted_i & ~ex_we_i;
  assign w_tmo     = (r_cnt == LP_TMO);
  assign w_addr_nz = |r_addr;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    dbg_req_ready_o = 1'b0;
    dbg_rsp_valid_o = 1'b0;
    dbg_rsp_data_o  = '0;
    dbg_rsp_err_o   = 1'b0;
    rf_we_o         = 1'b0;
    rf_addr_o       = '0;
    rf_wdata_o      = '0;
    case (r_state)
      S_IDLE: begin
        dbg_req_ready_o = 1'b1;
        if (w_accept) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // a free slot beats a timeout landing on the same cycle
        if (w_slot)     w_state_nxt = S_ACCESS;
        else if (w_tmo) w_state_nxt = S_RESP;
      end
      S_ACCESS: begin
        rf_we_o     = r_we & w_addr_nz;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        dbg_rsp_valid_o = 1'b1;
        dbg_rsp_data_o  = r_rsp_data;
        dbg_rsp_err_o   = r_rsp_err;
        if (dbg_rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (r_state != S_IDLE) begin
      rf_addr_o  = r_addr;
      rf_wdata_o = r_wdata;
    end
    // reset is synchronous, so the outputs are forced quiet while it is held
    if (rst) begin
      dbg_req_ready_o = 1'b0;
      dbg_rsp_valid_o = 1'b0;
      dbg_rsp_data_o  = '0;
      dbg_rsp_err_o   = 1'b0;
      rf_we_o         = 1'b0;
      rf_addr_o       = '0;
      rf_wdata_o      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= dbg_req_we_i;
            r_addr     <= dbg_req_addr_i;
            r_wdata    <= dbg_req_data_i;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_cnt      <= '0;
          end
        end
        S_WAIT: begin
          if (!w_slot) begin
            if (w_tmo) begin
              r_rsp_err  <= 1'b1;
              r_rsp_data <= '0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_ACCESS: begin
          // x0 reads as zero whatever the register file returns
          r_rsp_data <= (!r_we && w_addr_nz) ? rf_rdata_i : 32'd0;
          r_rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regs_dbg_access_ctrl.md
REGS_DBG_ACCESS_CTRL -- requirements
Module: regs_dbg_access_ctrl

Interface
REQ-001 The block SHALL have one parameter: WAIT_MAX, default 255, the number of cycles a request may wait for an access slot before it is aborted (legal range 1..65535).
REQ-002 The block SHALL provide the port clk, input, 1 bit: the single clock; all logic SHALL update on its rising edge.
REQ-003 The block SHALL provide the port rst, input, 1 bit: the reset, which SHALL be synchronous and active-high.
REQ-004 The block SHALL provide the port dbg_req_valid_i, input, 1 bit: a debug register-access request is present.
REQ-005 The block SHALL provide the port dbg_req_ready_o, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL provide the port dbg_req_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL provide the port dbg_req_addr_i, input, 5 bits: the register index.
REQ-008 The block SHALL provide the port dbg_req_data_i, input, 32 bits: the write data.
REQ-009 The block SHALL provide the port dbg_rsp_valid_o, output, 1 bit: a response is present.
REQ-010 The block SHALL provide the port dbg_rsp_ready_i, input, 1 bit: the requester takes the response.
REQ-011 The block SHALL provide the port dbg_rsp_data_o, output, 32 bits: the read data; it SHALL be 0 for writes and errors.
REQ-012 The block SHALL provide the port dbg_rsp_err_o, output, 1 bit: the request timed out.
REQ-013 The block SHALL provide the port halted_i, input, 1 bit: the core is halted.
REQ-014 The block SHALL provide the port ex_we_i, input, 1 bit: a core writeback to the register file is active this cycle.
REQ-015 The block SHALL provide the port rf_we_o, output, 1 bit: the debug-port write enable to the register file.
REQ-016 The block SHALL provide the port rf_addr_o, output, 5 bits: the debug-port address to the register file.
REQ-017 The block SHALL provide the port rf_wdata_o, output, 32 bits: the debug-port write data.
REQ-018 The block SHALL provide the port rf_rdata_i, input, 32 bits: the combinational debug-port read data from the register file.

Function
REQ-019 The FSM SHALL have the states IDLE, WAIT, ACCESS and RESP; dbg_req_ready_o SHALL be 1 only in IDLE.
REQ-020 On a request handshake (valid & ready), the block SHALL capture we, addr and data into holding registers, clear the wait counter and go to WAIT.
REQ-021 rf_addr_o and rf_wdata_o SHALL drive the held values from the cycle after acceptance until return to IDLE, and SHALL be 0 in IDLE.
REQ-022 In WAIT, if halted_i=1 and ex_we_i=0 in the same cycle, the block SHALL go to ACCESS on the next edge.
REQ-023 Otherwise in WAIT, the wait counter (16 bits) SHALL increment; when it equals WAIT_MAX-1 with no slot, the block SHALL go to RESP with err=1 and data=0.
REQ-024 If a slot and the timeout occur in the same cycle, the slot SHALL win.
REQ-025 ACCESS SHALL last exactly one cycle; for a write with held addr!=0, rf_we_o=1 in that cycle only.
REQ-026 A write to addr 0 SHALL assert no rf_we_o and SHALL complete with err=0.
REQ-027 For a read in ACCESS, the block SHALL register rf_rdata_i as the response data; a read of addr 0 SHALL return 0 regardless of rf_rdata_i.
REQ-028 If ex_we_i rises during ACCESS, the block SHALL still complete; it SHALL NOT abort.
REQ-029 In RESP, dbg_rsp_valid_o=1 and data/err SHALL stay stable until dbg_rsp_ready_i=1; the block SHALL then return to IDLE on that edge.
REQ-030 rf_we_o SHALL be 0 in every state other than ACCESS.
REQ-031 The minimum latency SHALL be 3 cycles from acceptance to dbg_rsp_valid_o (WAIT 1, ACCESS 1, RESP), and a new request SHALL be accepted no earlier than the cycle after the response handshake.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter and holding registers.
REQ-033 During reset, rf_we_o=0, dbg_rsp_valid_o=0, dbg_rsp_err_o=0, and all data and address outputs SHALL be 0.
REQ-034 During reset, dbg_req_ready_o SHALL be 0; it SHALL become 1 in the first cycle after rst falls.
REQ-035 Reset asserted mid-operation, including during ACCESS, SHALL discard the request with no response and no further rf_we_o.

Verification
REQ-036 The bench SHALL cover a write to x5 = 0xDEADBEEF with halted_i=1 and ex_we_i=0 -> rf_we_o is 1 for one cycle with addr 5 and the data, then the response arrives with err=0 and data=0.
REQ-037 The bench SHALL cover a read of x7 with rf_rdata_i=0x12345678 -> dbg_rsp_data_o=0x12345678 three cycles after acceptance.
REQ-038 The bench SHALL cover halted_i=0 throughout with WAIT_MAX=4 -> err=1, no rf_we_o, and the response in cycle 5 after acceptance.
REQ-039 The bench SHALL cover halted_i=1 with ex_we_i=1 for 3 cycles, then 0 -> ACCESS occurs only after ex_we_i falls.
REQ-040 The bench SHALL cover a write to x0 and a read of x0 with rf_rdata_i=0xFFFFFFFF -> no rf_we_o, err=0, and read data 0.
REQ-041 The bench SHALL cover dbg_rsp_ready_i held at 0 for 10 cycles -> the response stays stable and dbg_req_ready_o stays 0; rst pulsed during ACCESS -> IDLE with no response.
